slime_attack_gen: RTL and testbench

Produces the per-slime damage strobes `slim_damage[1:0]` consumed by the player health counter. It is the initiator side of the slime-to-player damage interface. Each slime runs an attack FSM: contact with the player starts a wind-up, a completed wind-up issues a one-clock strike, and a cooldown follows. Sits between the collision/sprite logic and the health counter; the attack state is also exported for sprite animation.

---
 rtl/slime_pkg.sv | 20 ++
 rtl/slime_attack_fsm.sv | 105 ++++++++++
 rtl/slime_attack_gen.sv | 67 ++++++
 tb/tb_slime_attack_gen.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/slime_pkg.sv
// Shared types and constants for the slime attack generator.
// Attack-state encodings, health thresholds and the enraged wind-up helper.
package slime_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WINDUP   = 2'd1,
      ST_STRIKE   = 2'd2,
      ST_COOLDOWN = 2'd3
   } attack_state_t;

   localparam int HEALTH_MAX    = 8;
   localparam int ENRAGE_HEALTH = 3;

   // Enraged wind-up is half the normal one, but never shorter than one tick.
   function automatic int enrage_threshold(input int windup_ticks);
      return ((windup_ticks / 2) < 1) ? 1 : (windup_ticks / 2);
   endfunction

endpackage

// File: rtl/slime_attack_fsm.sv
// One slime's attack FSM (IDLE -> WINDUP -> STRIKE -> COOLDOWN) with its tick counter.
// Optional SLIME_ENRAGE_EN halves the wind-up threshold while the player is at low health.
module slime_attack_fsm
   import slime_pkg::*;
#(
   parameter int WINDUP_TICKS   = 4,
   parameter int COOLDOWN_TICKS = 16,
   parameter int CNT_W          = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          tick,
   input  logic          contact,
   input  logic [3:0]    player_health,
   output logic          strike,
   output attack_state_t state
);

   localparam logic [CNT_W:0] WINDUP_MAX   = (CNT_W+1)'(WINDUP_TICKS);
   localparam logic [CNT_W:0] ENRAGE_MAX   = (CNT_W+1)'(enrage_threshold(WINDUP_TICKS));
   localparam logic [CNT_W:0] COOLDOWN_MAX = (CNT_W+1)'(COOLDOWN_TICKS);

   attack_state_t    state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             strike_reg;
   logic [CNT_W:0]   cnt_inc;
   logic [CNT_W:0]   threshold;
   logic             player_dead;

   assign player_dead = (player_health == 4'd0);
   assign cnt_inc     = {1'b0, cnt_reg} + 1'b1;

`ifdef SLIME_ENRAGE_EN
   assign threshold = (!player_dead && (player_health <= 4'(ENRAGE_HEALTH))) ? ENRAGE_MAX
                                                                             : WINDUP_MAX;
`else
   assign threshold = WINDUP_MAX;
`endif

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      if (player_dead) begin
         state_next = ST_IDLE;
         cnt_next   = '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (contact) begin
                  state_next = ST_WINDUP;
                  cnt_next   = '0;
               end
            end
            ST_WINDUP: begin
               // Losing contact beats a coincident completing tick.
               if (!contact) begin
                  state_next = ST_IDLE;
                  cnt_next   = '0;
               end else if (tick) begin
                  if (cnt_inc >= threshold) begin
                     state_next = ST_STRIKE;
                     cnt_next   = '0;
                  end else begin
                     cnt_next = cnt_inc[CNT_W-1:0];
                  end
               end
            end
            ST_STRIKE: begin
               state_next = ST_COOLDOWN;
               cnt_next   = '0;
            end
            ST_COOLDOWN: begin
               if (tick) begin
                  if (cnt_inc >= COOLDOWN_MAX) begin
                     state_next = ST_IDLE;
                     cnt_next   = '0;
                  end else begin
                     cnt_next = cnt_inc[CNT_W-1:0];
                  end
               end
            end
            default: begin
               state_next = ST_IDLE;
               cnt_next   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= ST_IDLE;
         cnt_reg    <= '0;
         strike_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         strike_reg <= (state_next == ST_STRIKE);
      end
   end

   assign strike = strike_reg;
   assign state  = state_reg;

endmodule

// File: rtl/slime_attack_gen.sv
// Per-slime damage strobe generator: one attack FSM per slime plus a saturating hit counter.
// Build option: define SLIME_ENRAGE_EN to shorten wind-up while the player is at low health.
module slime_attack_gen
   import slime_pkg::*;
#(
   parameter int N_SLIME        = 2,
   parameter int WINDUP_TICKS   = 4,
   parameter int COOLDOWN_TICKS = 16,
   parameter int CNT_W          = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tick,
   input  logic [N_SLIME-1:0]   contact,
   input  logic [3:0]           player_health,
   output logic [N_SLIME-1:0]   slim_damage,
   output logic [2*N_SLIME-1:0] attack_state,
   output logic [7:0]           hit_count
);

   localparam int SUM_W = 9 + $clog2(N_SLIME + 1);

   attack_state_t     state_vec [N_SLIME];
   logic [N_SLIME-1:0] strike_vec;
   logic [7:0]        hit_count_reg, hit_count_next;
   logic [SUM_W-1:0]  hit_sum;

   generate
      for (genvar gi = 0; gi < N_SLIME; gi++) begin : g_slime
         slime_attack_fsm #(
            .WINDUP_TICKS  (WINDUP_TICKS),
            .COOLDOWN_TICKS(COOLDOWN_TICKS),
            .CNT_W         (CNT_W)
         ) u_fsm (
            .clk          (clk),
            .reset        (reset),
            .tick         (tick),
            .contact      (contact[gi]),
            .player_health(player_health),
            .strike       (strike_vec[gi]),
            .state        (state_vec[gi])
         );
         assign attack_state[2*gi+1 -: 2] = state_vec[gi];
      end
   endgenerate

   assign slim_damage = strike_vec;

   always_comb begin
      hit_sum = SUM_W'(hit_count_reg);
      for (int i = 0; i < N_SLIME; i++) begin
         hit_sum = hit_sum + SUM_W'(strike_vec[i]);
      end
      hit_count_next = (hit_sum > SUM_W'(255)) ? 8'hFF : hit_sum[7:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hit_count_reg <= 8'd0;
      end else begin
         hit_count_reg <= hit_count_next;
      end
   end

   assign hit_count = hit_count_reg;

endmodule

// File: tb/tb_slime_attack_gen.sv
// Directed bench for slime_attack_gen; expected values are hand-derived per scenario.
// Scenario 6 expectations follow SLIME_ENRAGE_EN when that macro is defined.
module tb_slime_attack_gen;

   logic       clk;
   logic       reset;
   logic       tick;
   logic [1:0] contact;
   logic [3:0] player_health;
   logic [1:0] slim_damage;
   logic [3:0] attack_state;
   logic [7:0] hit_count;

   int total;
   int bad;

   slime_attack_gen dut (
      .clk          (clk),
      .reset        (reset),
      .tick         (tick),
      .contact      (contact),
      .player_health(player_health),
      .slim_damage  (slim_damage),
      .attack_state (attack_state),
      .hit_count    (hit_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end else begin
         $display("ok   %s: %0d", tag, got);
      end
   endtask

   // One clock with the given tick value; outputs are stable 1 time unit after the edge.
   task automatic cyc(input logic t);
      tick = t;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc(1'b0);
      cyc(1'b0);
      reset = 1'b0;
   endtask

   initial begin
      int n;
      int strikes;
      total = 0;
      bad = 0;
      reset = 1'b1;
      tick = 1'b0;
      contact = 2'b00;
      player_health = 4'd8;

      // 1: single slime, tick every 4 clks
      do_reset();
      check("rst_state", 32'(attack_state), 32'h0);
      check("rst_dmg", 32'(slim_damage), 32'h0);
      check("rst_hits", 32'(hit_count), 32'd0);
      contact = 2'b01;
      cyc(1'b0);
      check("t1_windup", 32'(attack_state), 32'b0001);
      for (int k = 1; k <= 4; k++) begin
         cyc(1'b1);
         if (k < 4) begin
            check("t1_still_windup", 32'(attack_state), 32'b0001);
            check("t1_no_dmg", 32'(slim_damage), 32'b00);
            repeat (3) cyc(1'b0);
         end
      end
      check("t1_strike_state", 32'(attack_state), 32'b0010);
      check("t1_strike_dmg", 32'(slim_damage), 32'b01);
      cyc(1'b0);
      check("t1_pulse_end", 32'(slim_damage), 32'b00);
      check("t1_cooldown", 32'(attack_state), 32'b0011);
      check("t1_hits", 32'(hit_count), 32'd1);
      for (int k = 1; k <= 16; k++) begin
         cyc(1'b1);
         if (k == 15) check("t1_cool_15", 32'(attack_state), 32'b0011);
         if (k < 16) repeat (3) cyc(1'b0);
      end
      check("t1_back_idle", 32'(attack_state), 32'b0000);
      cyc(1'b0);
      check("t1_rewindup", 32'(attack_state), 32'b0001);

      // 2: contact lost together with the 4th tick
      do_reset();
      contact = 2'b01;
      cyc(1'b0);
      repeat (3) cyc(1'b1);
      contact = 2'b00;
      cyc(1'b1);
      check("t2_abort_state", 32'(attack_state), 32'b0000);
      check("t2_abort_dmg", 32'(slim_damage), 32'b00);
      contact = 2'b01;
      cyc(1'b0);
      repeat (3) cyc(1'b1);
      check("t2_fresh_windup", 32'(attack_state), 32'b0001);
      cyc(1'b1);
      check("t2_strike_dmg", 32'(slim_damage), 32'b01);
      cyc(1'b0);
      check("t2_hits", 32'(hit_count), 32'd1);

      // 3: both slimes strike together
      do_reset();
      contact = 2'b11;
      cyc(1'b0);
      check("t3_windup", 32'(attack_state), 32'b0101);
      repeat (4) cyc(1'b1);
      check("t3_strike_state", 32'(attack_state), 32'b1010);
      check("t3_dmg", 32'(slim_damage), 32'b11);
      cyc(1'b0);
      check("t3_hits", 32'(hit_count), 32'd2);
      check("t3_cooldown", 32'(attack_state), 32'b1111);

      // 4: dead player during STRIKE and mid-WINDUP
      do_reset();
      contact = 2'b11;
      cyc(1'b0);
      repeat (4) cyc(1'b1);
      player_health = 4'd0;
      cyc(1'b0);
      check("t4_dead_strike_state", 32'(attack_state), 32'b0000);
      check("t4_dead_strike_dmg", 32'(slim_damage), 32'b00);
      player_health = 4'd8;
      cyc(1'b0);
      check("t4_windup_again", 32'(attack_state), 32'b0101);
      repeat (2) cyc(1'b1);
      player_health = 4'd0;
      cyc(1'b1);
      check("t4_dead_windup", 32'(attack_state), 32'b0000);
      repeat (3) cyc(1'b1);
      check("t4_stay_idle", 32'(attack_state), 32'b0000);
      check("t4_no_dmg", 32'(slim_damage), 32'b00);
      player_health = 4'd8;
      cyc(1'b0);
      check("t4_restored", 32'(attack_state), 32'b0101);
      repeat (4) cyc(1'b1);
      check("t4_restored_fresh_count", 32'(slim_damage), 32'b11);

      // 5: reach 200 hits, reset in COOLDOWN, then saturate
      do_reset();
      contact = 2'b11;
      player_health = 4'd8;
      n = 0;
      while (hit_count != 8'd200 && n < 3000) begin
         cyc(1'b1);
         n++;
      end
      check("t5_cycles_to_200", 32'(n), 32'd2184);
      check("t5_hits_200", 32'(hit_count), 32'd200);
      check("t5_in_cooldown", 32'(attack_state), 32'b1111);
      reset = 1'b1;
      cyc(1'b1);
      reset = 1'b0;
      check("t5_rst_state", 32'(attack_state), 32'h0);
      check("t5_rst_dmg", 32'(slim_damage), 32'h0);
      check("t5_rst_hits", 32'(hit_count), 32'd0);
      strikes = 0;
      for (int c = 0; c < 3400; c++) begin
         cyc(1'b1);
         strikes += int'(slim_damage[0]) + int'(slim_damage[1]);
      end
      check("t5_strikes", 32'(strikes), 32'd310);
      check("t5_saturated", 32'(hit_count), 32'd255);

      // 6: low health wind-up
      do_reset();
      player_health = 4'd3;
      contact = 2'b01;
      cyc(1'b0);
      repeat (2) cyc(1'b1);
`ifdef SLIME_ENRAGE_EN
      check("t6_enraged_2ticks", 32'(attack_state), 32'b0010);
`else
      check("t6_normal_2ticks", 32'(attack_state), 32'b0001);
      repeat (2) cyc(1'b1);
      check("t6_normal_4ticks", 32'(attack_state), 32'b0010);
`endif
      do_reset();
      player_health = 4'd4;
      contact = 2'b01;
      cyc(1'b0);
      repeat (2) cyc(1'b1);
      check("t6_h4_cnt2", 32'(attack_state), 32'b0001);
      player_health = 4'd3;
      cyc(1'b1);
`ifdef SLIME_ENRAGE_EN
      check("t6_drop_strike", 32'(slim_damage), 32'b01);
`else
      check("t6_drop_no_strike", 32'(slim_damage), 32'b00);
      cyc(1'b1);
      check("t6_drop_4th", 32'(slim_damage), 32'b01);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
